// File: rtl/store_merge_if.sv
// Handshake and memory-port bundle for store_merge_unit.
// The master side is the control unit plus data memory; the slave side is the merge engine.
interface store_merge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              start;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              inval;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output start, mode, addr, wdata, inval, mem_rdata,
      input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport slave (
      input  start, mode, addr, wdata, inval, mem_rdata,
      output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
   );
endinterface

// File: rtl/store_merge_unit.sv
// Read-modify-write engine for sb/sh/sw stores with lane placement by address offset.
// Optional macro STORE_MERGE_FWD_EN merges sub-word stores into the last written word.
//
// state | meaning
// IDLE  | waiting for start; mem_addr is 0
// READ  | mem_rd strobe for the aligned word
// WAIT  | counting down MEM_LAT-1; mem_rdata sampled and merged at zero
// WRITE | mem_wr strobe with merged word
// FIN   | done (and err) pulse; busy low
module store_merge_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input logic        clk,
   input logic        reset,
   store_merge_if.slave bus
);
   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);
   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_BYTE = 2'b01;
   localparam logic [1:0] MODE_HALF = 2'b10;

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

   state_t            st, st_n;
   logic [2:0]        cnt, cnt_n;
   logic [1:0]        c_mode, c_mode_n;
   logic [OFF_W-1:0]  c_off, c_off_n;
   logic [15:0]       c_wdata, c_wdata_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              rd_q, rd_n;
   logic              wr_q, wr_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              err_q, err_n;

   logic [OFF_W-1:0]  off;
   logic [ADDR_W-1:0] aligned;
   logic              req_ok;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_word;

   assign off     = bus.addr[OFF_W-1:0];
   assign aligned = {bus.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // Byte data is replicated into every lane, half data into every lane pair;
   // the lane mask then picks which replicated lanes replace the base word.
   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] base,
      input logic [15:0]       src,
      input logic [1:0]        m,
      input logic [OFF_W-1:0]  o
   );
      logic [DATA_W-1:0] placed;
      logic [DATA_W-1:0] res;
      placed = (m == MODE_BYTE) ? {LANES{src[7:0]}} : {(LANES/2){src}};
      res = base;
      for (int i = 0; i < LANES; i++) begin
         if (i == int'(o) || (m == MODE_HALF && i == int'(o) + 1))
            res[8*i +: 8] = placed[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      req_ok = 1'b0;
      case (bus.mode)
         MODE_WORD: req_ok = (off == '0);
         MODE_BYTE: req_ok = 1'b1;
         MODE_HALF: req_ok = ~off[0];
         default:   req_ok = 1'b0;
      endcase
   end

`ifdef STORE_MERGE_FWD_EN
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_word;
   logic              last_valid;

   assign fwd_hit  = last_valid && !bus.inval && (aligned == last_addr);
   assign fwd_word = last_word;

   // inval and error completions take priority over a same-cycle write capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_addr  <= '0;
         last_word  <= '0;
         last_valid <= 1'b0;
      end else begin
         if (wr_q) begin
            last_addr  <= addr_q;
            last_word  <= wdata_q;
            last_valid <= 1'b1;
         end
         if (bus.inval || err_q)
            last_valid <= 1'b0;
      end
   end
`else
   logic unused_inval;
   assign unused_inval = bus.inval;
   assign fwd_hit      = 1'b0;
   assign fwd_word     = '0;
`endif

   always_comb begin
      st_n      = st;
      cnt_n     = cnt;
      c_mode_n  = c_mode;
      c_off_n   = c_off;
      c_wdata_n = c_wdata;
      addr_n    = addr_q;
      wdata_n   = wdata_q;
      err_n     = 1'b0;

      case (st)
         IDLE: begin
            addr_n  = '0;
            wdata_n = '0;
            if (bus.start) begin
               c_mode_n  = bus.mode;
               c_off_n   = off;
               c_wdata_n = bus.wdata[15:0];
               addr_n    = aligned;
               if (!req_ok) begin
                  st_n  = FIN;
                  err_n = 1'b1;
               end else if (bus.mode == MODE_WORD) begin
                  st_n    = WRITE;
                  wdata_n = bus.wdata;
               end else if (fwd_hit) begin
                  st_n    = WRITE;
                  wdata_n = merge(fwd_word, bus.wdata[15:0], bus.mode, off);
               end else begin
                  st_n = READ;
               end
            end
         end
         READ: begin
            cnt_n = LAT_M1;
            st_n  = WAIT;
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               wdata_n = merge(bus.mem_rdata, c_wdata, c_mode, c_off);
               st_n    = WRITE;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         WRITE: st_n = FIN;
         FIN: begin
            st_n    = IDLE;
            addr_n  = '0;
            wdata_n = '0;
         end
         default: st_n = IDLE;
      endcase

      // Strobes are decoded from the next state so they appear registered in that state's cycle.
      rd_n   = (st_n == READ);
      wr_n   = (st_n == WRITE);
      busy_n = (st_n == READ) || (st_n == WAIT) || (st_n == WRITE);
      done_n = (st_n == FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= IDLE;
         cnt     <= '0;
         c_mode  <= '0;
         c_off   <= '0;
         c_wdata <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st      <= st_n;
         cnt     <= cnt_n;
         c_mode  <= c_mode_n;
         c_off   <= c_off_n;
         c_wdata <= c_wdata_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         rd_q    <= rd_n;
         wr_q    <= wr_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         err_q   <= err_n;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;
   assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Directed self-checking bench for store_merge_unit with a MEM_LAT=2 memory read model.
module tb_store_merge_unit;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0]    rd_word = '0;
   logic [LAT-1:0] rd_pipe = '0;

   store_merge_if #(.DATA_W(32), .ADDR_W(32)) bus();

   store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Read data is valid only in the cycle MEM_LAT cycles after mem_rd, zero otherwise.
   always @(posedge clk) rd_pipe <= (rd_pipe << 1) | LAT'(bus.mem_rd);
   assign bus.mem_rdata = rd_pipe[LAT-1] ? rd_word : 32'h0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic rd, input logic wr,
                          input logic bsy, input logic dn, input logic er);
      chk1({tag, " mem_rd"}, bus.mem_rd, rd);
      chk1({tag, " mem_wr"}, bus.mem_wr, wr);
      chk1({tag, " busy"},   bus.busy,   bsy);
      chk1({tag, " done"},   bus.done,   dn);
      chk1({tag, " err"},    bus.err,    er);
   endtask

   // Word store or forwarded sub-word store: write in t+1, done in t+2.
   task automatic run_word(input logic [31:0] a, input logic [1:0] m, input logic [31:0] wd,
                           input logic [31:0] exp, input string tag);
      bus.start = 1'b1; bus.mode = m; bus.addr = a; bus.wdata = wd;
      step();
      bus.start = 1'b0; bus.addr = ~a; bus.wdata = ~wd;
      chk_ctl({tag, " t+1"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, " mem_addr"},  bus.mem_addr,  {a[31:2], 2'b00});
      chk({tag, " mem_wdata"}, bus.mem_wdata, exp);
      step();
      chk_ctl({tag, " t+2"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk({tag, " fin addr"}, bus.mem_addr, {a[31:2], 2'b00});
      step();
      chk_ctl({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, " idle addr"}, bus.mem_addr, 32'h0);
   endtask

   // Sub-word store through the read path; hold keeps start high until IDLE is reached.
   task automatic run_sub(input logic [31:0] a, input logic [1:0] m, input logic [31:0] wd,
                          input logic [31:0] rdw, input logic [31:0] exp, input bit hold,
                          input string tag);
      rd_word = rdw;
      bus.start = 1'b1; bus.mode = m; bus.addr = a; bus.wdata = wd;
      step();
      if (!hold) bus.start = 1'b0;
      bus.addr = ~a; bus.wdata = ~wd; bus.mode = 2'b11;
      chk_ctl({tag, " t+1"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk({tag, " rd addr"}, bus.mem_addr, {a[31:2], 2'b00});
      for (int k = 0; k < LAT; k++) begin
         step();
         chk_ctl({tag, " wait"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step();
      chk_ctl({tag, " write"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, " mem_addr"},  bus.mem_addr,  {a[31:2], 2'b00});
      chk({tag, " mem_wdata"}, bus.mem_wdata, exp);
      step();
      chk_ctl({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_ctl({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({tag, " idle addr"}, bus.mem_addr, 32'h0);
      if (hold) begin
         bus.start = 1'b0;
         step();
         chk_ctl({tag, " idle2"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic run_err(input logic [31:0] a, input logic [1:0] m, input string tag);
      bus.start = 1'b1; bus.mode = m; bus.addr = a; bus.wdata = 32'h5A5A5A5A;
      step();
      bus.start = 1'b0;
      chk_ctl({tag, " t+1"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk_ctl({tag, " t+2"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_inval();
      bus.inval = 1'b1;
      step();
      bus.inval = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.mode = 2'b00; bus.addr = '0; bus.wdata = '0; bus.inval = 1'b0;
      step(); step();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset mem_addr",  bus.mem_addr,  32'h0);
      chk("reset mem_wdata", bus.mem_wdata, 32'h0);
      reset = 1'b0;
      step();

      run_word(32'h100, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, "sw");

      run_err(32'h201, 2'b10, "sh_misaligned");
      run_err(32'h102, 2'b00, "sw_misaligned");
      run_err(32'h100, 2'b11, "mode11");

      run_sub(32'h103, 2'b01, 32'h000000AB, 32'h11223344, 32'hAB223344, 1'b0, "sb_lane3");
      run_sub(32'h202, 2'b10, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 1'b1, "sh_hold");
      run_sub(32'h300, 2'b10, 32'hFFFF9876, 32'hA5A5A5A5, 32'hA5A59876, 1'b0, "sh_lane0");

      // Reset while in WAIT aborts the store.
      rd_word = 32'h11223344;
      bus.start = 1'b1; bus.mode = 2'b01; bus.addr = 32'h401; bus.wdata = 32'h12;
      step();
      bus.start = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk_ctl("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_wait mem_addr",  bus.mem_addr,  32'h0);
      chk("rst_wait mem_wdata", bus.mem_wdata, 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_ctl("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      run_word(32'h500, 2'b00, 32'h0BADF00D, 32'h0BADF00D, "sw_after_rst");

      // Consecutive byte stores to one word, then again across an inval pulse.
      pulse_inval();
      run_sub(32'h100, 2'b01, 32'h00000055, 32'h11223344, 32'h11223355, 1'b0, "fwd_first");
`ifdef STORE_MERGE_FWD_EN
      run_word(32'h101, 2'b01, 32'h00000066, 32'h11226655, "fwd_hit");
`else
      run_sub(32'h101, 2'b01, 32'h00000066, 32'h11223344, 32'h11226644, 1'b0, "fwd_off");
`endif
      pulse_inval();
      run_sub(32'h102, 2'b01, 32'h00000077, 32'h11223344, 32'h11773344, 1'b0, "fwd_inval");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
